// File: rtl/iob_rom_2p_arbiter_if.sv
// Bundle of the two requester ports and the shared ROM port.
// The arbiter takes the slave view. The requesters and the ROM macro take the master view.
interface iob_rom_2p_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
);
    logic              r1_valid_i;
    logic [ADDR_W-1:0] r1_addr_i;
    logic              r1_ready_o;
    logic              r1_rvalid_o;
    logic [DATA_W-1:0] r1_rdata_o;

    logic              r2_valid_i;
    logic [ADDR_W-1:0] r2_addr_i;
    logic              r2_ready_o;
    logic              r2_rvalid_o;
    logic [DATA_W-1:0] r2_rdata_o;

    logic              rom_en_o;
    logic [ADDR_W-1:0] rom_addr_o;
    logic [DATA_W-1:0] rom_rdata_i;

    modport slave (
        input  r1_valid_i, r1_addr_i, r2_valid_i, r2_addr_i, rom_rdata_i,
        output r1_ready_o, r1_rvalid_o, r1_rdata_o,
        output r2_ready_o, r2_rvalid_o, r2_rdata_o,
        output rom_en_o, rom_addr_o
    );

    modport master (
        output r1_valid_i, r1_addr_i, r2_valid_i, r2_addr_i, rom_rdata_i,
        input  r1_ready_o, r1_rvalid_o, r1_rdata_o,
        input  r2_ready_o, r2_rvalid_o, r2_rdata_o,
        input  rom_en_o, rom_addr_o
    );
endinterface

// File: rtl/iob_rom_2p_arbiter.sv
// Two-port read arbiter in front of one synchronous single-port ROM (1-cycle latency).
// The default build uses round-robin on conflicts, driven by a registered last_grant pointer.
// Define IOB_ROM_2P_ARB_FIXED_PRIO_EN to select fixed priority instead. In that build port 1
// always wins a conflict and the pointer is not built.
// Each port gets a 1-cycle rvalid strobe. The port's last word is held stable between reads.
module iob_rom_2p_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
) (
    input logic                 clk_i,
    input logic                 arst_n_i,
    iob_rom_2p_arbiter_if.slave bus
);
    // index 0 = port 1, index 1 = port 2
    logic [1:0]             req;
    logic [1:0]             grant;
    logic [1:0]             rvalid_q;
    logic [1:0][DATA_W-1:0] hold_q;
    logic [1:0][DATA_W-1:0] rdata;

    assign req = {bus.r2_valid_i, bus.r1_valid_i};

`ifdef IOB_ROM_2P_ARB_FIXED_PRIO_EN
    assign grant[0] = req[0];
    assign grant[1] = req[1] & ~req[0];
`else
    typedef enum logic {LAST_P1 = 1'b0, LAST_P2 = 1'b1} last_e;
    last_e last_grant;

    // On a conflict, grant the port that did not win the previous accept.
    always_comb begin
        grant = req;
        if (&req)
            grant = (last_grant == LAST_P2) ? 2'b01 : 2'b10;
    end

    // The pointer moves only on an accept. Reset points at port 2 so port 1 wins first.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i)
            last_grant <= LAST_P2;
        else if (grant[0])
            last_grant <= LAST_P1;
        else if (grant[1])
            last_grant <= LAST_P2;
    end
`endif

    // Accept implies a ROM read this cycle, so the data returns next cycle to the grantee.
    // The hold register captures that word at the end of its rvalid cycle.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            rvalid_q <= '0;
            hold_q   <= '0;
        end else begin
            rvalid_q <= grant;
            for (int p = 0; p < 2; p++)
                if (rvalid_q[p])
                    hold_q[p] <= bus.rom_rdata_i;
        end
    end

    // During rvalid the port sees the ROM word directly. Otherwise it sees its own hold register.
    always_comb begin
        for (int p = 0; p < 2; p++)
            rdata[p] = rvalid_q[p] ? bus.rom_rdata_i : hold_q[p];
    end

    assign bus.rom_en_o    = |grant;
    assign bus.rom_addr_o  = grant[1] ? bus.r2_addr_i : bus.r1_addr_i;

    assign bus.r1_ready_o  = grant[0];
    assign bus.r2_ready_o  = grant[1];
    assign bus.r1_rvalid_o = rvalid_q[0];
    assign bus.r2_rvalid_o = rvalid_q[1];
    assign bus.r1_rdata_o  = rdata[0];
    assign bus.r2_rdata_o  = rdata[1];
endmodule

// File: tb/tb_iob_rom_2p_arbiter.sv
module tb_iob_rom_2p_arbiter;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 10;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  iob_rom_2p_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  iob_rom_2p_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk_i    (clk),
    .arst_n_i (arst_n),
    .bus      (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
    if (a == 10'd3) return 32'h0000_0033;
    return 32'hA5A5_0000 | {22'd0, a};
  endfunction

  always @(posedge clk)
    if (bus.rom_en_o) bus.rom_rdata_i <= rom_word(bus.rom_addr_o);

  task automatic chk(input string tag, input logic ok,
                     input logic [63:0] got, input logic [63:0] want);
    total++;
    if (ok !== 1'b1) begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v1, input logic [ADDR_W-1:0] a1,
                       input logic v2, input logic [ADDR_W-1:0] a2);
    bus.r1_valid_i = v1;
    bus.r1_addr_i  = a1;
    bus.r2_valid_i = v2;
    bus.r2_addr_i  = a2;
    #1;
  endtask

  initial begin
    bus.rom_rdata_i = '0;
    drive(1'b1, 10'd5, 1'b1, 10'd7);

    cyc(); cyc();
    drive(1'b1, 10'd5, 1'b1, 10'd7);
    chk("rst_r1_rvalid", bus.r1_rvalid_o === 1'b0, bus.r1_rvalid_o, 0);
    chk("rst_r2_rvalid", bus.r2_rvalid_o === 1'b0, bus.r2_rvalid_o, 0);
    chk("rst_r1_rdata", bus.r1_rdata_o === 32'h0, bus.r1_rdata_o, 0);
    chk("rst_r2_rdata", bus.r2_rdata_o === 32'h0, bus.r2_rdata_o, 0);

    arst_n = 1'b1;
    drive(1'b1, 10'd5, 1'b0, 10'd0);
    chk("rel_r1_ready", bus.r1_ready_o === 1'b1, bus.r1_ready_o, 1);
    chk("rel_rom_en", bus.rom_en_o === 1'b1, bus.rom_en_o, 1);
    chk("rel_rom_addr", bus.rom_addr_o === 10'd5, bus.rom_addr_o, 5);
    cyc(); drive(1'b0, 10'd0, 1'b0, 10'd0);
    chk("rel_r1_rvalid", bus.r1_rvalid_o === 1'b1, bus.r1_rvalid_o, 1);
    chk("rel_r1_rdata", bus.r1_rdata_o === 32'hA5A5_0005, bus.r1_rdata_o, 32'hA5A5_0005);
    chk("rel_r2_rvalid", bus.r2_rvalid_o === 1'b0, bus.r2_rvalid_o, 0);
    chk("idle_ready", {bus.r2_ready_o, bus.r1_ready_o, bus.rom_en_o} === 3'b000,
        {bus.r2_ready_o, bus.r1_ready_o, bus.rom_en_o}, 0);
    cyc(); drive(1'b0, 10'd0, 1'b0, 10'd0);
    chk("idle_r1_rvalid", bus.r1_rvalid_o === 1'b0, bus.r1_rvalid_o, 0);
    chk("idle_r1_hold", bus.r1_rdata_o === 32'hA5A5_0005, bus.r1_rdata_o, 32'hA5A5_0005);

    cyc(); drive(1'b0, 10'd0, 1'b1, 10'd3);
    chk("solo_r2_ready0", bus.r2_ready_o === 1'b1, bus.r2_ready_o, 1);
    chk("solo_r2_rvalid0", bus.r2_rvalid_o === 1'b0, bus.r2_rvalid_o, 0);
    for (int i = 1; i < 4; i++) begin
      cyc(); drive(1'b0, 10'd0, 1'b1, 10'd3);
      chk("solo_r2_ready", bus.r2_ready_o === 1'b1, bus.r2_ready_o, 1);
      chk("solo_r2_rvalid", bus.r2_rvalid_o === 1'b1, bus.r2_rvalid_o, 1);
      chk("solo_r2_rdata", bus.r2_rdata_o === 32'h33, bus.r2_rdata_o, 32'h33);
      chk("solo_r1_rdata", bus.r1_rdata_o === 32'hA5A5_0005, bus.r1_rdata_o, 32'hA5A5_0005);
    end
    cyc(); drive(1'b0, 10'd0, 1'b0, 10'd0);
    chk("solo_r2_rvalid4", bus.r2_rvalid_o === 1'b1, bus.r2_rvalid_o, 1);
    chk("solo_r1_rvalid", bus.r1_rvalid_o === 1'b0, bus.r1_rvalid_o, 0);
    cyc(); drive(1'b0, 10'd0, 1'b0, 10'd0);
    chk("solo_r2_done", bus.r2_rvalid_o === 1'b0, bus.r2_rvalid_o, 0);
    chk("solo_r2_hold", bus.r2_rdata_o === 32'h33, bus.r2_rdata_o, 32'h33);

`ifndef IOB_ROM_2P_ARB_FIXED_PRIO_EN
    cyc(); drive(1'b1, 10'd1, 1'b1, 10'd2);
    chk("rr0_ready", {bus.r2_ready_o, bus.r1_ready_o} === 2'b01, {bus.r2_ready_o, bus.r1_ready_o}, 1);
    chk("rr0_rom_addr", bus.rom_addr_o === 10'd1, bus.rom_addr_o, 1);
    cyc(); drive(1'b1, 10'd1, 1'b1, 10'd2);
    chk("rr1_ready", {bus.r2_ready_o, bus.r1_ready_o} === 2'b10, {bus.r2_ready_o, bus.r1_ready_o}, 2);
    chk("rr1_rom_addr", bus.rom_addr_o === 10'd2, bus.rom_addr_o, 2);
    chk("rr1_rvalid", {bus.r2_rvalid_o, bus.r1_rvalid_o} === 2'b01, {bus.r2_rvalid_o, bus.r1_rvalid_o}, 1);
    chk("rr1_r1_rdata", bus.r1_rdata_o === 32'hA5A5_0001, bus.r1_rdata_o, 32'hA5A5_0001);
    chk("rr1_r2_hold", bus.r2_rdata_o === 32'h33, bus.r2_rdata_o, 32'h33);
    cyc(); drive(1'b1, 10'd1, 1'b1, 10'd2);
    chk("rr2_ready", {bus.r2_ready_o, bus.r1_ready_o} === 2'b01, {bus.r2_ready_o, bus.r1_ready_o}, 1);
    chk("rr2_rvalid", {bus.r2_rvalid_o, bus.r1_rvalid_o} === 2'b10, {bus.r2_rvalid_o, bus.r1_rvalid_o}, 2);
    chk("rr2_r2_rdata", bus.r2_rdata_o === 32'hA5A5_0002, bus.r2_rdata_o, 32'hA5A5_0002);
    chk("rr2_r1_hold", bus.r1_rdata_o === 32'hA5A5_0001, bus.r1_rdata_o, 32'hA5A5_0001);
    cyc(); drive(1'b1, 10'd1, 1'b1, 10'd2);
    chk("rr3_ready", {bus.r2_ready_o, bus.r1_ready_o} === 2'b10, {bus.r2_ready_o, bus.r1_ready_o}, 2);
    chk("rr3_rvalid", {bus.r2_rvalid_o, bus.r1_rvalid_o} === 2'b01, {bus.r2_rvalid_o, bus.r1_rvalid_o}, 1);
    cyc(); drive(1'b0, 10'd0, 1'b0, 10'd0);
    chk("rr4_rvalid", {bus.r2_rvalid_o, bus.r1_rvalid_o} === 2'b10, {bus.r2_rvalid_o, bus.r1_rvalid_o}, 2);
    chk("rr4_r2_rdata", bus.r2_rdata_o === 32'hA5A5_0002, bus.r2_rdata_o, 32'hA5A5_0002);

    cyc(); drive(1'b1, 10'd1, 1'b0, 10'd0);
    chk("fair_r1_solo", bus.r1_ready_o === 1'b1, bus.r1_ready_o, 1);
    cyc(); drive(1'b0, 10'd0, 1'b1, 10'd2);
    chk("fair_r2_solo", bus.r2_ready_o === 1'b1, bus.r2_ready_o, 1);
    cyc(); drive(1'b1, 10'd1, 1'b1, 10'd2);
    chk("fair_conf1", {bus.r2_ready_o, bus.r1_ready_o} === 2'b01, {bus.r2_ready_o, bus.r1_ready_o}, 1);
    chk("fair_conf1_rv", bus.r2_rvalid_o === 1'b1, bus.r2_rvalid_o, 1);
    cyc(); drive(1'b1, 10'd1, 1'b1, 10'd2);
    chk("fair_conf2", {bus.r2_ready_o, bus.r1_ready_o} === 2'b10, {bus.r2_ready_o, bus.r1_ready_o}, 2);
    chk("fair_conf2_rv", bus.r1_rvalid_o === 1'b1, bus.r1_rvalid_o, 1);
    cyc(); drive(1'b0, 10'd0, 1'b0, 10'd0);
    chk("fair_conf2_rv2", bus.r2_rvalid_o === 1'b1, bus.r2_rvalid_o, 1);
`else
    for (int i = 0; i < 3; i++) begin
      cyc(); drive(1'b1, 10'd1, 1'b1, 10'd2);
      chk("fp_ready", {bus.r2_ready_o, bus.r1_ready_o} === 2'b01, {bus.r2_ready_o, bus.r1_ready_o}, 1);
      chk("fp_rom_addr", bus.rom_addr_o === 10'd1, bus.rom_addr_o, 1);
    end
    cyc(); drive(1'b0, 10'd0, 1'b1, 10'd2);
    chk("fp_r2_ready", {bus.r2_ready_o, bus.r1_ready_o} === 2'b10, {bus.r2_ready_o, bus.r1_ready_o}, 2);
    chk("fp_r1_rdata", bus.r1_rdata_o === 32'hA5A5_0001, bus.r1_rdata_o, 32'hA5A5_0001);
    cyc(); drive(1'b0, 10'd0, 1'b0, 10'd0);
    chk("fp_r2_rdata", bus.r2_rdata_o === 32'hA5A5_0002, bus.r2_rdata_o, 32'hA5A5_0002);
`endif

    cyc(); drive(1'b1, 10'd5, 1'b0, 10'd0);
    chk("mid_pre_ready", bus.r1_ready_o === 1'b1, bus.r1_ready_o, 1);
    cyc(); drive(1'b0, 10'd0, 1'b0, 10'd0);
    cyc(); drive(1'b1, 10'd4, 1'b0, 10'd0);
    chk("mid_ready", bus.r1_ready_o === 1'b1, bus.r1_ready_o, 1);
    #3;
    arst_n = 1'b0;
    drive(1'b0, 10'd0, 1'b0, 10'd0);
    chk("mid_rst_r1_rdata", bus.r1_rdata_o === 32'h0, bus.r1_rdata_o, 0);
    cyc(); drive(1'b0, 10'd0, 1'b0, 10'd0);
    chk("mid_rst_r1_rvalid", bus.r1_rvalid_o === 1'b0, bus.r1_rvalid_o, 0);
    arst_n = 1'b1;
    cyc(); drive(1'b1, 10'd1, 1'b1, 10'd2);
    chk("mid_post_rvalid", bus.r1_rvalid_o === 1'b0, bus.r1_rvalid_o, 0);
    chk("mid_post_conf", {bus.r2_ready_o, bus.r1_ready_o} === 2'b01, {bus.r2_ready_o, bus.r1_ready_o}, 1);
    cyc(); drive(1'b0, 10'd0, 1'b0, 10'd0);
    chk("mid_post_rdata", bus.r1_rdata_o === 32'hA5A5_0001, bus.r1_rdata_o, 32'hA5A5_0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/iob_rom_2p_arbiter.md
Name: iob_rom_2p_arbiter

Overview:
- Shares one synchronous single-port ROM (1-cycle read latency, read on enable) between two read requesters.
- Arbitrates between them with a registered round-robin pointer.
- Issues the single ROM enable/address, steers the returned word back to the winning port with a per-port valid strobe, and holds each port's last word stable.
- Sits between two masters (e.g. instruction fetch and data load) and the ROM macro.

Parameters:
- DATA_W, 32, ROM word width in bits.
- ADDR_W, 10, ROM address width in bits.

Ports:
- clk_i  input  1  clock; all state on rising edge.
- arst_n_i  input  1  asynchronous active-low reset.
- r1_valid_i  input  1  port 1 read request.
- r1_addr_i  input  ADDR_W  port 1 word address.
- r1_ready_o  output  1  port 1 request accepted this cycle.
- r1_rvalid_o  output  1  port 1 read data valid.
- r1_rdata_o  output  DATA_W  port 1 read data.
- r2_valid_i  input  1  port 2 read request.
- r2_addr_i  input  ADDR_W  port 2 word address.
- r2_ready_o  output  1  port 2 request accepted this cycle.
- r2_rvalid_o  output  1  port 2 read data valid.
- r2_rdata_o  output  DATA_W  port 2 read data.
- rom_en_o  output  1  ROM read enable.
- rom_addr_o  output  ADDR_W  ROM address.
- rom_rdata_i  input  DATA_W  ROM data, valid the cycle after rom_en_o.

Behaviour:
- Single clock domain.
- Reset is asynchronous assert, active-low, and clears the following:
  - last_grant register = port 2, so port 1 wins the first conflict.
  - r1_rvalid_o = r2_rvalid_o = 0.
  - Both hold registers = 0, so rN_rdata_o reads 0.
  - rom_en_o, r1_ready_o and r2_ready_o are combinational and read 0 while no valid is asserted.
- Grant (combinational, same cycle):
  - Only r1_valid_i: grant port 1.
  - Only r2_valid_i: grant port 2.
  - Both: grant the port that is not last_grant.
  - rN_ready_o = grant to N.
  - A request is accepted when valid & ready.
  - Requesters must hold addr stable while valid & !ready.
- ROM drive:
  - rom_en_o = r1_ready_o | r2_ready_o.
  - rom_addr_o = granted port's address; r1_addr_i when no grant.
- State update on accept:
  - last_grant <= granted port.
  - No accept leaves last_grant unchanged.
- Response, latency exactly 1 cycle:
  - Accept at cycle t gives rN_rvalid_o = 1 at t+1, for one cycle per accept.
  - rN_rdata_o = rom_rdata_i during that cycle, and is captured into the port N hold register at the end of it.
  - Outside rvalid cycles, rN_rdata_o = hold register, which is unchanged by the other port's reads.
- Throughput:
  - One accept per cycle total; back-to-back accepts allowed.
  - With both valid continuously, grants alternate 1,2,1,2...
- Simultaneous events:
  - A new accept in the same cycle as the previous response is legal.
  - The response goes to the previous grantee; the new rvalid follows next cycle.
- No backpressure on the response side: requesters must consume rvalid immediately.
- Reset mid-operation: a pending response is dropped (rvalid not asserted after reset release), and the pointer returns to its reset value.

Optional Feature:
- Macro IOB_ROM_2P_ARB_FIXED_PRIO_EN.
- Defined:
  - Fixed priority: port 1 always wins a conflict, and port 2 is granted only when r1_valid_i = 0.
  - The last_grant register is not implemented.
  - Matches the legacy port-1-first sharing.
- Undefined (default): round-robin as described above.

Test Plan:
- Reset: hold arst_n_i = 0 with both valids high -> rvalid outputs 0, rdata outputs 0. Release with ROM[5] = 0xA5A5_0005 and r1 requesting addr 5 -> r1_ready_o = 1 at t, r1_rvalid_o = 1 and r1_rdata_o = 0xA5A5_0005 at t+1.
- Solo port 2: r2 reads addr 3 (ROM[3] = 0x33) for 4 consecutive cycles -> r2_ready_o high every cycle, r2_rvalid_o high cycles t+1..t+4, r1 outputs unchanged.
- Conflict round-robin: both valid continuously, r1 addr 1, r2 addr 2 -> grants 1,2,1,2. r1_rdata_o = ROM[1] and r2_rdata_o = ROM[2] on alternating rvalid cycles, each holding its value while idle.
- Fairness after solo: r2 wins one accept alone, then both request next cycle -> port 1 granted.
- Reset mid-read: accept r1 at t, assert arst_n_i at t+0.5 -> no r1_rvalid_o after release; next conflict granted to port 1.
- Fixed-priority build (IOB_ROM_2P_ARB_FIXED_PRIO_EN): both valid for 3 cycles -> port 1 granted all 3, r2_ready_o = 0. Drop r1 -> r2 granted next cycle.
